pc_alu_core: RTL and testbench
==============================

// Module: pc_alu_core
// PURPOSE
//  Execute-stage arithmetic plus fetch-stage PC state for the 5-stage RV32 pipeline.
//  Holds the 12-bit program counter with a stall write-enable and supplies PC+4.
//  Contains the combinational 32-bit ALU, which produces result, zero and neg flags for branch decision.
//  The ALU is purely combinational. The PC is the only state in the block.
// PARAMETERS
//  PC_W    12  program-counter width in bits; byte address into instruction memory
//  XLEN    32  ALU datapath width
// PORTS
//  clk         in   1      rising-edge clock (single clock domain)
//  rst         in   1      synchronous, active-high reset
//  pc_we       in   1      PC write enable; 0 = stall (hazard unit), 1 = load pc_next
//  pc_next     in   PC_W   next PC value (PC mux output: branch target or PC+4)
//  pc          out  PC_W   current PC register value (drives instruction memory)
//  pc_plus4    out  PC_W   pc + 4, combinational
//  alu_op      in   5      operation select (encodings below)
//  alu_sign    in   1      1 = signed compare, 0 = unsigned compare
//  alu_a       in   XLEN   operand 1 (after forwarding)
//  alu_b       in   XLEN   operand 2 (after forwarding / immediate select)
//  alu_result  out  XLEN   ALU result, combinational
//  alu_zero    out  1      alu_result == 0
//  alu_neg     out  1      alu_a < alu_b, using the compare selected by alu_sign
// BEHAVIOUR
//  PC register:
//   - On a rising clk edge with rst=1: pc <= 0. rst has priority over pc_we.
//   - Otherwise, on a rising clk edge: if pc_we=1 then pc <= pc_next; else pc holds.
//   - pc is 0 from the first edge on which rst is sampled high. Before any reset, pc is don't-care.
//  PC+4:
//   - pc_plus4 = (pc + 4) mod 2^PC_W; 0xFFC wraps to 0x000.
//   - pc_plus4 follows pc combinationally in the same cycle, so it also reads 4 after reset.
//  ALU: fully combinational; rst has no effect; zero latency.
//   Encodings of alu_op:
//   - 0 ADD: a+b, mod 2^32
//   - 1 SUB: a-b, mod 2^32
//   - 2 AND
//   - 3 OR
//   - 4 XOR
//   - 5 SLL: a << b[4:0]
//   - 6 SRL: logical right shift by b[4:0]
//   - 7 SRA: arithmetic right shift by b[4:0]
//   - 8 SLT: result = {31'b0, lt}, where lt is signed if alu_sign=1, else unsigned
//   - 9 PASSB: result = b (LUI)
//   - 10 MUL: low 32 bits of a*b
//   - 11..31: result = 0
//   Shift amounts use only b[4:0]; b[31:5] is ignored.
//   - alu_zero = (alu_result == 0) for every op. Branch compares use SUB, so alu_zero=1 means a==b.
//   - alu_neg = lt for every op, independent of alu_op. lt is the true comparison result, not result[31], so it is overflow-free.
//   - No flags are registered and there are no exceptions. Overflow wraps silently.
// STRUCTURE
//  Shared package pc_alu_pkg:
//   - alu_op_e: 5-bit enum with ALU_ADD..ALU_MUL using the values above
//   - localparams PC_W and XLEN, and PC_STEP = 4
//  One sub-module, alu_core, holds the combinational ALU.
//  The PC register and the +4 adder live in the top level.
// TESTING
//  - Reset/stall: rst=1 for one edge -> pc=0x000, pc_plus4=0x004.
//    Then pc_we=1, pc_next=0x010 -> pc=0x010.
//    Then pc_we=0, pc_next=0x020 -> pc stays 0x010.
//    Then rst=1 with pc_we=1 -> pc=0x000.
//  - PC wrap: pc_next=0xFFC loaded -> pc_plus4=0x000.
//  - Add/sub: ADD 0x7FFFFFFF+1 -> 0x80000000, zero=0.
//    SUB 5-5 -> 0, zero=1.
//    SUB 3-5 -> 0xFFFFFFFE.
//  - Compare: a=0xFFFFFFFF, b=1.
//    alu_sign=1 -> neg=1, SLT=1.
//    alu_sign=0 -> neg=0, SLT=0.
//    a=0x80000000, b=1, sign=1 -> neg=1, with no overflow error.
//  - Shifts: a=0x80000010, b=0x24 (shamt 4).
//    SLL -> 0x00000100; SRL -> 0x08000001; SRA -> 0xF8000001.
//  - Logic/misc: a=0xF0F0, b=0x0FF0.
//    AND=0x00F0, OR=0xFFF0, XOR=0xFF00.
//    PASSB=0x0FF0; MUL 6*7=42; alu_op=20 -> result 0, zero=1.

Source files
------------

// File: rtl/pc_alu_pkg.sv
// pc_alu_pkg: shared widths, PC step and ALU opcode encodings
package pc_alu_pkg;
  localparam int PC_W = 12;
  localparam int XLEN = 32;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_PASSB = 5'd9,
    ALU_MUL   = 5'd10
  } alu_op_e;
endpackage

// File: rtl/pc_alu_core_alu.sv
// alu_core: combinational 32-bit ALU with zero and less-than flags
// ports: op/sign/a/b in; result, zero (result==0), neg (a<b per sign) out
module alu_core
  import pc_alu_pkg::*;
(
  input  logic [4:0]      op,
  input  logic            sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            neg
);
  logic lt;
  // true comparison rather than the sign of a-b, so it cannot be fooled by overflow
  assign lt = sign ? ($signed(a) < $signed(b)) : (a < b);
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
      ALU_SRA:   result = $signed(a) >>> b[4:0];
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt};
      ALU_PASSB: result = b;
      ALU_MUL:   result = a * b;
      default:   result = '0;
    endcase
  end
  assign zero = result == '0;
  assign neg  = lt;
endmodule

// File: rtl/pc_alu_core.sv
// pc_alu_core: fetch PC register with stall enable plus PC+4, and execute-stage ALU
// ports: clk/rst, pc_we/pc_next -> pc, pc_plus4; alu_op/alu_sign/alu_a/alu_b -> alu_result/zero/neg
module pc_alu_core
  import pc_alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_we,
  input  logic [PC_W-1:0] pc_next,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  input  logic [4:0]      alu_op,
  input  logic            alu_sign,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero,
  output logic            alu_neg
);
  always_ff @(posedge clk)
    if (rst) pc <= '0;
    else if (pc_we) pc <= pc_next;
  assign pc_plus4 = pc + PC_STEP;
  alu_core u_alu (
    .op(alu_op),
    .sign(alu_sign),
    .a(alu_a),
    .b(alu_b),
    .result(alu_result),
    .zero(alu_zero),
    .neg(alu_neg)
  );
endmodule

// File: tb/tb_pc_alu_core.sv
// tb_pc_alu_core: directed vectors for PC register and ALU with hand-computed expectations
module tb_pc_alu_core;
  logic        clk = 0;
  logic        rst = 0;
  logic        pc_we = 0;
  logic [11:0] pc_next = '0;
  logic [11:0] pc;
  logic [11:0] pc_plus4;
  logic [4:0]  alu_op = '0;
  logic        alu_sign = 0;
  logic [31:0] alu_a = '0;
  logic [31:0] alu_b = '0;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_neg;
  int checks = 0;
  int errors = 0;
  pc_alu_core dut (
    .clk(clk), .rst(rst), .pc_we(pc_we), .pc_next(pc_next), .pc(pc), .pc_plus4(pc_plus4),
    .alu_op(alu_op), .alu_sign(alu_sign), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_neg(alu_neg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic we, input logic [11:0] nxt);
    rst = r;
    pc_we = we;
    pc_next = nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic [4:0] op, input logic s, input logic [31:0] a, input logic [31:0] b);
    alu_op = op;
    alu_sign = s;
    alu_a = a;
    alu_b = b;
    #1;
  endtask
  initial begin
    step(1, 0, 12'h000);
    check("rst_pc", 32'(pc), 32'h000);
    check("rst_pc4", 32'(pc_plus4), 32'h004);
    step(0, 1, 12'h010);
    check("load_pc", 32'(pc), 32'h010);
    check("load_pc4", 32'(pc_plus4), 32'h014);
    step(0, 0, 12'h020);
    check("stall_pc", 32'(pc), 32'h010);
    step(1, 1, 12'h030);
    check("rst_prio_pc", 32'(pc), 32'h000);
    step(0, 1, 12'hFFC);
    check("wrap_pc", 32'(pc), 32'hFFC);
    check("wrap_pc4", 32'(pc_plus4), 32'h000);
    alu(5'd0, 1, 32'h7FFFFFFF, 32'h1);
    check("add_res", alu_result, 32'h80000000);
    check("add_zero", 32'(alu_zero), 0);
    check("add_neg", 32'(alu_neg), 0);
    alu(5'd1, 1, 32'd5, 32'd5);
    check("sub_eq_res", alu_result, 0);
    check("sub_eq_zero", 32'(alu_zero), 1);
    alu(5'd1, 1, 32'd3, 32'd5);
    check("sub_neg_res", alu_result, 32'hFFFFFFFE);
    check("sub_neg_flag", 32'(alu_neg), 1);
    alu(5'd8, 1, 32'hFFFFFFFF, 32'h1);
    check("slt_s_res", alu_result, 1);
    check("slt_s_neg", 32'(alu_neg), 1);
    alu(5'd8, 0, 32'hFFFFFFFF, 32'h1);
    check("slt_u_res", alu_result, 0);
    check("slt_u_neg", 32'(alu_neg), 0);
    check("slt_u_zero", 32'(alu_zero), 1);
    alu(5'd1, 1, 32'h80000000, 32'h1);
    check("ovf_res", alu_result, 32'h7FFFFFFF);
    check("ovf_neg", 32'(alu_neg), 1);
    alu(5'd5, 1, 32'h80000010, 32'h24);
    check("sll", alu_result, 32'h00000100);
    alu(5'd6, 1, 32'h80000010, 32'h24);
    check("srl", alu_result, 32'h08000001);
    alu(5'd7, 1, 32'h80000010, 32'h24);
    check("sra", alu_result, 32'hF8000001);
    check("sra_neg", 32'(alu_neg), 1);
    alu(5'd2, 1, 32'hF0F0, 32'h0FF0);
    check("and", alu_result, 32'h00F0);
    alu(5'd3, 1, 32'hF0F0, 32'h0FF0);
    check("or", alu_result, 32'hFFF0);
    alu(5'd4, 1, 32'hF0F0, 32'h0FF0);
    check("xor", alu_result, 32'hFF00);
    alu(5'd9, 1, 32'hF0F0, 32'h0FF0);
    check("passb", alu_result, 32'h0FF0);
    alu(5'd10, 1, 32'd6, 32'd7);
    check("mul", alu_result, 32'd42);
    alu(5'd10, 1, 32'h10000, 32'h10001);
    check("mul_low", alu_result, 32'h00010000);
    alu(5'd20, 1, 32'hF0F0, 32'h0FF0);
    check("undef_res", alu_result, 0);
    check("undef_zero", 32'(alu_zero), 1);
    step(1, 0, 12'h000);
    check("alu_no_rst", alu_result, 0);
    alu(5'd0, 1, 32'd2, 32'd3);
    check("alu_in_rst", alu_result, 32'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
